// File: rtl/serial_alu_ctrl_pkg.sv
// Shared encodings for the serial ALU sequencer: ALU operations, FSM states
// and a small helper used by the control logic.
package serial_alu_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_ADD = 2'b10,
      OP_SUB = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // ADD and SUB share the adder path; only they produce a meaningful carry.
   function automatic logic op_is_arith(input alu_op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/serial_alu_ctrl_alu_bit_slice.sv
// One-bit ALU slice: AND/OR gates plus a full adder. SUB arrives here as an ADD
// because the sequencer pre-inverts b and seeds the carry with 1.
module alu_bit_slice
   import serial_alu_ctrl_pkg::*;
(
   input  logic    a,
   input  logic    b,
   input  logic    cin,
   input  alu_op_e op,
   output logic    r,
   output logic    cout
);

   logic and_s;
   logic or_s;
   logic sum_s;
   logic carry_s;

   assign and_s   = a & b;
   assign or_s    = a | b;
   assign sum_s   = a ^ b ^ cin;
   assign carry_s = and_s | (cin & (a ^ b));

   // Select the slice output for the requested operation.
   always_comb begin
      r    = 1'b0;
      cout = 1'b0;
      case (op)
         OP_AND: begin
            r    = and_s;
            cout = 1'b0;
         end
         OP_OR: begin
            r    = or_s;
            cout = 1'b0;
         end
         OP_ADD, OP_SUB: begin
            r    = sum_s;
            cout = carry_s;
         end
         default: begin
            r    = 1'b0;
            cout = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: captures an operand pair, runs it LSB first through
// a single alu_bit_slice, one bit per clock, then publishes result and flags.
module serial_alu_ctrl
   import serial_alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry_out
);

   state_e           state_q,     state_d;
   alu_op_e          op_q,        op_d;
   logic [WIDTH-1:0] a_sr_q,      a_sr_d;
   logic [WIDTH-1:0] b_sr_q,      b_sr_d;
   logic [WIDTH-1:0] res_sr_q,    res_sr_d;
   logic             carry_q,     carry_d;
   logic [CNT_W-1:0] counter_q,   counter_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic             zero_q,      zero_d;
   logic             carry_out_q, carry_out_d;

   logic slice_r_s;
   logic slice_cout_s;

   alu_bit_slice u_slice (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .op   (op_q),
      .r    (slice_r_s),
      .cout (slice_cout_s)
   );

   // Next-state logic for the FSM, datapath shift registers and output registers.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_sr_d      = a_sr_q;
      b_sr_d      = b_sr_q;
      res_sr_d    = res_sr_q;
      carry_d     = carry_q;
      counter_d   = counter_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      result_d    = result_q;
      zero_d      = zero_q;
      carry_out_d = carry_out_q;

      case (state_q)
         ST_IDLE: begin
            // busy_q still high here means this is the done cycle; start is ignored.
            if (start && !busy_q) begin
               op_d      = alu_op_e'(op);
               a_sr_d    = a;
               b_sr_d    = (alu_op_e'(op) == OP_SUB) ? ~b : b;
               carry_d   = (alu_op_e'(op) == OP_SUB) ? 1'b1 : 1'b0;
               counter_d = {CNT_W{1'b0}};
               busy_d    = 1'b1;
               state_d   = ST_RUN;
            end else begin
               busy_d    = 1'b0;
            end
         end
         ST_RUN: begin
            res_sr_d  = {slice_r_s, res_sr_q[WIDTH-1:1]};
            a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
            carry_d   = op_is_arith(op_q) ? slice_cout_s : 1'b0;
            counter_d = counter_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (counter_q == CNT_W'(WIDTH - 1)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            done_d      = 1'b1;
            result_d    = res_sr_q;
            zero_d      = (res_sr_q == {WIDTH{1'b0}});
            carry_out_d = op_is_arith(op_q) ? carry_q : 1'b0;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Single register bank for FSM state, datapath and outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_AND;
         a_sr_q      <= {WIDTH{1'b0}};
         b_sr_q      <= {WIDTH{1'b0}};
         res_sr_q    <= {WIDTH{1'b0}};
         carry_q     <= 1'b0;
         counter_q   <= {CNT_W{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= {WIDTH{1'b0}};
         zero_q      <= 1'b0;
         carry_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_sr_q      <= a_sr_d;
         b_sr_q      <= b_sr_d;
         res_sr_q    <= res_sr_d;
         carry_q     <= carry_d;
         counter_q   <= counter_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         carry_out_q <= carry_out_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign carry_out = carry_out_q;

endmodule
